// File: rtl/simon_cfg_pkg.sv
// Shared types and constants for the simon configuration-port AXI4-Lite initiator.
package simon_cfg_pkg;

    localparam int CFG_ADDR_WIDTH = 32;
    localparam int CFG_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RSP
    } state_e;

    // States in which a bus transaction is outstanding and the watchdog runs.
    function automatic logic is_bus_active(state_e s);
        return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/simon_cfg_watchdog.sv
// Per-transaction watchdog: loadable counter with enable and a combinational expiry flag.
module simon_cfg_watchdog
    import simon_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The load value of 1 makes the acceptance cycle itself count toward the budget.
    always_comb begin
        count_d = count_q;
        expired = (TIMEOUT_CYCLES != 0) && enable && (count_q >= LIMIT);
        if (load) begin
            count_d = CNT_W'(1);
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/simon_cfg_axil_master.sv
// AXI4-Lite initiator for the simon cfg port: one outstanding command, registered outputs, watchdog abort.
module simon_cfg_axil_master
    import simon_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH     = CFG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CFG_DATA_WIDTH,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_simon_cfg,
    input  logic                  rst_simon_cfg,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  bus_hung,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  bus_hung_q, bus_hung_d;

    logic accept;
    logic abort;
    logic wd_expired;
    logic aw_done;
    logic w_done;

    simon_cfg_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk_simon_cfg),
        .rst    (rst_simon_cfg),
        .load   (accept),
        .enable (is_bus_active(state_q)),
        .expired(wd_expired)
    );

    assign aw_done = !awvalid_q || m_awready;
    assign w_done  = !wvalid_q || m_wready;

    // A completing handshake always takes priority over watchdog expiry in the same cycle.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        bus_hung_d    = bus_hung_q;
        accept        = 1'b0;
        abort         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    accept        = 1'b1;
                    cmd_ready_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    addr_d        = cmd_addr & ~ADDR_WIDTH'(3);
                    wdata_d       = cmd_wdata;
                    wstrb_d       = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR: begin
                if (awvalid_q && m_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (m_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_rdata;
                    rsp_resp_d  = m_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abandoning the hung bus is the one place valid is withdrawn without a handshake.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            bus_hung_d    = 1'b1;
            state_d       = ST_RSP;
        end
    end

    always_ff @(posedge clk_simon_cfg or posedge rst_simon_cfg) begin
        if (rst_simon_cfg) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
            bus_hung_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            bus_hung_q    <= bus_hung_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign bus_hung    = bus_hung_q;
    assign m_araddr    = addr_q;
    assign m_awaddr    = addr_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign m_arvalid   = arvalid_q;
    assign m_awvalid   = awvalid_q;
    assign m_wvalid    = wvalid_q;
    assign m_rready    = rready_q;
    assign m_bready    = bready_q;
    assign m_arprot    = 3'b000;
    assign m_awprot    = 3'b000;

endmodule

// File: tb/tb_simon_cfg_axil_master.sv
// Directed bench for simon_cfg_axil_master; the responder is driven cycle by cycle from the stimulus sequence.
module tb_simon_cfg_axil_master;

    logic        clk_simon_cfg = 1'b0;
    logic        rst_simon_cfg = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        bus_hung;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;

    int checks = 0;
    int failures = 0;

    simon_cfg_axil_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .STRB_WIDTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_simon_cfg(clk_simon_cfg),
        .rst_simon_cfg(rst_simon_cfg),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .bus_hung     (bus_hung),
        .m_araddr     (m_araddr),
        .m_arprot     (m_arprot),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_rdata      (m_rdata),
        .m_rresp      (m_rresp),
        .m_rvalid     (m_rvalid),
        .m_rready     (m_rready),
        .m_awaddr     (m_awaddr),
        .m_awprot     (m_awprot),
        .m_awvalid    (m_awvalid),
        .m_awready    (m_awready),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_wvalid     (m_wvalid),
        .m_wready     (m_wready),
        .m_bresp      (m_bresp),
        .m_bvalid     (m_bvalid),
        .m_bready     (m_bready)
    );

    always #5 clk_simon_cfg = ~clk_simon_cfg;

    task automatic tick();
        @(posedge clk_simon_cfg);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one command; returns #1 after the edge on which it was accepted.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb);
        checkOutput("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_valids", {28'd0, m_awvalid, m_wvalid, m_arvalid, rsp_valid}, 32'd0);
        checkOutput("rst_readies", {30'd0, m_bready, m_rready}, 32'd0);
        checkOutput("rst_flags", {30'd0, rsp_timeout, bus_hung}, 32'd0);
        checkOutput("rst_araddr", m_araddr, 32'd0);
        checkOutput("rst_resp", {30'd0, rsp_resp}, 32'd0);
        checkOutput("prot", {26'd0, m_awprot, m_arprot}, 32'd0);
        rst_simon_cfg = 1'b0;
        tick();

        // Write, registered responder, rsp_ready held high early
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        checkOutput("w1_valids", {30'd0, m_awvalid, m_wvalid}, 32'd3);
        checkOutput("w1_awaddr", m_awaddr, 32'h0000_0010);
        checkOutput("w1_wdata", m_wdata, 32'hDEAD_BEEF);
        checkOutput("w1_wstrb", {28'd0, m_wstrb}, 32'hF);
        checkOutput("w1_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        tick();
        checkOutput("w1_valids_wait", {30'd0, m_awvalid, m_wvalid}, 32'd3);
        checkOutput("w1_early_rsp_ready", {31'd0, rsp_valid}, 32'd0);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick();
        m_awready = 1'b0;
        m_wready  = 1'b0;
        checkOutput("w1_valids_done", {30'd0, m_awvalid, m_wvalid}, 32'd0);
        checkOutput("w1_bready", {31'd0, m_bready}, 32'd1);
        checkOutput("w1_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
        m_bvalid = 1'b1;
        m_bresp  = 2'b00;
        tick();
        m_bvalid = 1'b0;
        checkOutput("w1_rsp_valid_4cyc", {31'd0, rsp_valid}, 32'd1);
        checkOutput("w1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        checkOutput("w1_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("w1_bready_off", {31'd0, m_bready}, 32'd0);
        tick();
        rsp_ready = 1'b0;
        checkOutput("w1_rsp_done", {31'd0, rsp_valid}, 32'd0);
        checkOutput("w1_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // Read, ARREADY after 3 cycles, RVALID 5 cycles later; unaligned address
        applyStimulus(1'b0, 32'h0000_0107, 32'd0, 4'h0);
        checkOutput("r_arvalid", {31'd0, m_arvalid}, 32'd1);
        checkOutput("r_araddr_aligned", m_araddr, 32'h0000_0104);
        checkOutput("r_no_awvalid", {31'd0, m_awvalid}, 32'd0);
        tick();
        checkOutput("r_araddr_hold1", m_araddr, 32'h0000_0104);
        tick();
        checkOutput("r_araddr_hold2", m_araddr, 32'h0000_0104);
        checkOutput("r_arvalid_hold", {31'd0, m_arvalid}, 32'd1);
        checkOutput("r_rready_early", {31'd0, m_rready}, 32'd0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        checkOutput("r_arvalid_drop", {31'd0, m_arvalid}, 32'd0);
        checkOutput("r_rready", {31'd0, m_rready}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("r_rready_wait", {31'd0, m_rready}, 32'd1);
        checkOutput("r_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234_5678;
        m_rresp  = 2'b00;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = 32'hFFFF_FFFF;
        checkOutput("r_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("r_rdata", rsp_rdata, 32'h1234_5678);
        checkOutput("r_resp", {30'd0, rsp_resp, rsp_timeout}, 32'd0);
        checkOutput("r_rready_drop", {31'd0, m_rready}, 32'd0);

        // Response stall: rsp_ready low for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("stall_rdata", rsp_rdata, 32'h1234_5678);
            checkOutput("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("stall_rsp_done", {31'd0, rsp_valid}, 32'd0);
        checkOutput("stall_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // Write: WREADY two cycles before AWREADY, DECERR passed through, BVALID held long
        applyStimulus(1'b1, 32'h0000_0020, 32'hA5A5_0001, 4'h3);
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0;
        checkOutput("wa_w_first", {30'd0, m_awvalid, m_wvalid}, 32'd2);
        checkOutput("wa_bready_early", {31'd0, m_bready}, 32'd0);
        tick();
        checkOutput("wa_aw_waiting", {30'd0, m_awvalid, m_wvalid}, 32'd2);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        checkOutput("wa_both_done", {30'd0, m_awvalid, m_wvalid}, 32'd0);
        checkOutput("wa_bready", {31'd0, m_bready}, 32'd1);
        m_bvalid = 1'b1;
        m_bresp  = 2'b11;
        tick();
        checkOutput("wa_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("wa_decerr", {30'd0, rsp_resp}, 32'd3);
        checkOutput("wa_no_timeout", {31'd0, rsp_timeout}, 32'd0);
        checkOutput("wa_one_b", {31'd0, m_bready}, 32'd0);
        tick();
        m_bvalid = 1'b0;
        checkOutput("wa_still_one_b", {31'd0, m_bready}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("wa_rsp_done", {31'd0, rsp_valid}, 32'd0);

        // Write: AWREADY and WREADY in the same cycle, SLVERR passed through
        applyStimulus(1'b1, 32'h0000_0024, 32'h0000_00FF, 4'h1);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick();
        m_awready = 1'b0;
        m_wready  = 1'b0;
        checkOutput("ws_both_done", {30'd0, m_awvalid, m_wvalid}, 32'd0);
        checkOutput("ws_bready", {31'd0, m_bready}, 32'd1);
        m_bvalid = 1'b1;
        m_bresp  = 2'b10;
        tick();
        m_bvalid = 1'b0;
        checkOutput("ws_slverr", {30'd0, rsp_resp}, 32'd2);
        checkOutput("ws_no_timeout", {31'd0, rsp_timeout}, 32'd0);
        checkOutput("ws_no_hung", {31'd0, bus_hung}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout: B never arrives, 16-cycle watchdog
        applyStimulus(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick();
        m_awready = 1'b0;
        m_wready  = 1'b0;
        checkOutput("to_bready", {31'd0, m_bready}, 32'd1);
        for (int i = 0; i < 13; i++) tick();
        checkOutput("to_not_yet", {31'd0, rsp_valid}, 32'd0);
        checkOutput("to_bready_wait", {31'd0, m_bready}, 32'd1);
        tick();
        checkOutput("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("to_slverr", {30'd0, rsp_resp}, 32'd2);
        checkOutput("to_flag", {31'd0, rsp_timeout}, 32'd1);
        checkOutput("to_bus_hung", {31'd0, bus_hung}, 32'd1);
        checkOutput("to_bready_drop", {31'd0, m_bready}, 32'd0);
        checkOutput("to_rdata", rsp_rdata, 32'd0);
        m_bvalid = 1'b1;
        m_bresp  = 2'b00;
        tick();
        m_bvalid = 1'b0;
        checkOutput("to_late_b_resp", {30'd0, rsp_resp}, 32'd2);
        checkOutput("to_late_b_bready", {31'd0, m_bready}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("to_rsp_done", {31'd0, rsp_valid}, 32'd0);
        checkOutput("to_hung_sticky", {31'd0, bus_hung}, 32'd1);

        // Reset during RD_DATA
        applyStimulus(1'b0, 32'h0000_0040, 32'd0, 4'h0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        checkOutput("rr_rready", {31'd0, m_rready}, 32'd1);
        tick();
        #2;
        rst_simon_cfg = 1'b1;
        #1;
        checkOutput("rr_async_valids", {28'd0, m_awvalid, m_wvalid, m_arvalid, rsp_valid}, 32'd0);
        checkOutput("rr_async_readies", {30'd0, m_bready, m_rready}, 32'd0);
        checkOutput("rr_async_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rr_async_hung_clr", {31'd0, bus_hung}, 32'd0);
        tick();
        rst_simon_cfg = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFE_CAFE;
        for (int i = 0; i < 3; i++) tick();
        m_rvalid = 1'b0;
        checkOutput("rr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rr_rready_low", {31'd0, m_rready}, 32'd0);
        checkOutput("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
